// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: hazard-control state encoding, fixed instruction words
// and the load-use detection rule.
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [XLEN-1:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } hz_state_e;

    // A load in EX writing a register that ID reads needs one bubble; x0 never hazards.
    function automatic logic load_use_hit(
        input logic                 ex_load,
        input logic [REG_IDX_W-1:0] ex_wb_reg,
        input logic [REG_IDX_W-1:0] id_rs1_reg,
        input logic [REG_IDX_W-1:0] id_rs2_reg
    );
        return ex_load && (ex_wb_reg != '0) &&
               ((ex_wb_reg == id_rs1_reg) || (ex_wb_reg == id_rs2_reg));
    endfunction

endpackage

// File: rtl/rv32_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module rv32_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-jump flush, EBREAK drain and halt,
// plus saturating stall/flush performance counters.
module rv32_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1_reg,
    input  logic [REG_IDX_W-1:0] id_rs2_reg,
    input  logic                 id_jump,
    input  logic                 id_ebreak,
    input  logic                 ex_load,
    input  logic [REG_IDX_W-1:0] ex_wb_reg,
    output logic                 pc_hold,
    output logic                 id_hold,
    output logic                 ex_bubble,
    output logic                 id_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_e          state_q;
    hz_state_e          state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_d;
    logic               load_use;
    logic               stall_inc;
    logic               flush_inc;

    assign load_use = load_use_hit(ex_load, ex_wb_reg, id_rs1_reg, id_rs2_reg);

    // Stalls must act in the cycle the hazard is seen, so controls decode state and inputs.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pc_hold   = 1'b0;
        id_hold   = 1'b0;
        ex_bubble = 1'b0;
        id_flush  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (load_use) begin
                    pc_hold   = 1'b1;
                    id_hold   = 1'b1;
                    ex_bubble = 1'b1;
                    stall_inc = 1'b1;
                end else if (id_ebreak) begin
                    pc_hold   = 1'b1;
                    ex_bubble = 1'b1;
                    state_d   = ST_DRAIN;
                    drain_d   = DRAIN_W'(DRAIN_CYCLES - 1);
                end else if (id_jump) begin
                    state_d   = ST_FLUSH;
                    flush_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Whatever ID holds now was fetched down the wrong path, EBREAK included.
                id_flush  = 1'b1;
                ex_bubble = 1'b1;
                state_d   = ST_RUN;
            end
            ST_DRAIN: begin
                pc_hold   = 1'b1;
                id_hold   = 1'b1;
                ex_bubble = 1'b1;
                if (drain_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_HALT: begin
                pc_hold   = 1'b1;
                id_hold   = 1'b1;
                ex_bubble = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign halted = (state_q == ST_HALT);

    rv32_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    rv32_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Scoreboard bench for rv32_hazard_ctrl: a default instance and a narrow-counter, short-drain
// instance share stimulus; a timeline model predicts every cycle's outputs.
module tb_rv32_hazard_ctrl;

    localparam int NDUT = 2;

    typedef struct packed {
        logic        pc;
        logic        id;
        logic        bub;
        logic        fl;
        logic        halt;
        logic [31:0] st;
        logic [31:0] fc;
    } obs_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] cyc;
        obs_t        o;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_reg, id_rs2_reg, ex_wb_reg;
    logic       id_jump, id_ebreak, ex_load;

    logic [NDUT-1:0] pc_hold, id_hold, ex_bubble, id_flush, halted;
    logic [31:0]     stall_cnt0, flush_cnt0;
    logic [2:0]      stall_cnt1, flush_cnt1;

    always #5 clk = ~clk;

    rv32_hazard_ctrl u_dut0 (
        .clk(clk), .reset(reset),
        .id_rs1_reg(id_rs1_reg), .id_rs2_reg(id_rs2_reg),
        .id_jump(id_jump), .id_ebreak(id_ebreak),
        .ex_load(ex_load), .ex_wb_reg(ex_wb_reg),
        .pc_hold(pc_hold[0]), .id_hold(id_hold[0]), .ex_bubble(ex_bubble[0]),
        .id_flush(id_flush[0]), .halted(halted[0]),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    rv32_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .id_rs1_reg(id_rs1_reg), .id_rs2_reg(id_rs2_reg),
        .id_jump(id_jump), .id_ebreak(id_ebreak),
        .ex_load(ex_load), .ex_wb_reg(ex_wb_reg),
        .pc_hold(pc_hold[1]), .id_hold(id_hold[1]), .ex_bubble(ex_bubble[1]),
        .id_flush(id_flush[1]), .halted(halted[1]),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    // Reference model: the pipeline is described by when EBREAK was accepted (halt is due
    // 1+DRAIN cycles later), whether the previous cycle took a jump, and two event tallies.
    int          drain_len [NDUT] = '{3, 1};
    logic [31:0] cnt_max   [NDUT] = '{32'hFFFF_FFFF, 32'h0000_0007};
    int          eb_cyc    [NDUT] = '{-1, -1};
    bit          in_flush  [NDUT] = '{0, 0};
    logic [31:0] m_stall   [NDUT] = '{0, 0};
    logic [31:0] m_flush   [NDUT] = '{0, 0};
    bit          model_ok = 1'b0;
    int          cyc = 0;

    ent_t q0[$];
    ent_t q1[$];
    int   checks = 0;
    int   failures = 0;

    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] wb, input logic ld, input logic jmp, input logic eb);
        bit   lu, halt_m, drain_m, run_m, nf;
        obs_t o;
        ent_t e;
        @(posedge clk);
        #1;
        reset = rst; id_rs1_reg = rs1; id_rs2_reg = rs2; ex_wb_reg = wb;
        ex_load = ld; id_jump = jmp; id_ebreak = eb;
        lu = ld && (wb != 5'd0) && (wb == rs1 || wb == rs2);
        for (int d = 0; d < NDUT; d++) begin
            halt_m  = (eb_cyc[d] >= 0) && (cyc >= eb_cyc[d] + 1 + drain_len[d]);
            drain_m = (eb_cyc[d] >= 0) && !halt_m;
            run_m   = !halt_m && !drain_m && !in_flush[d];
            o = '0;
            if (halt_m || drain_m) begin
                o.pc = 1'b1; o.id = 1'b1; o.bub = 1'b1; o.halt = halt_m;
            end else if (in_flush[d]) begin
                o.fl = 1'b1; o.bub = 1'b1;
            end else if (lu) begin
                o.pc = 1'b1; o.id = 1'b1; o.bub = 1'b1;
            end else if (eb) begin
                o.pc = 1'b1; o.bub = 1'b1;
            end
            o.st = m_stall[d];
            o.fc = m_flush[d];
            e.chk = model_ok;
            e.cyc = 32'(cyc);
            e.o   = o;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            if (rst) begin
                eb_cyc[d] = -1; in_flush[d] = 1'b0; m_stall[d] = '0; m_flush[d] = '0;
            end else begin
                nf = run_m && !lu && !eb && jmp;
                if (run_m && lu && m_stall[d] != cnt_max[d]) m_stall[d] = m_stall[d] + 1;
                if (nf && m_flush[d] != cnt_max[d]) m_flush[d] = m_flush[d] + 1;
                if (run_m && !lu && eb) eb_cyc[d] = cyc;
                in_flush[d] = nf;
            end
        end
        if (rst) model_ok = 1'b1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_obs(input int d, input ent_t e, input obs_t a);
        checks++;
        if (a !== e.o) begin
            failures++;
            $display("FAIL dut%0d cyc%0d got pc=%b id=%b bub=%b fl=%b halt=%b st=%0h fc=%0h exp pc=%b id=%b bub=%b fl=%b halt=%b st=%0h fc=%0h",
                     d, e.cyc, a.pc, a.id, a.bub, a.fl, a.halt, a.st, a.fc,
                     e.o.pc, e.o.id, e.o.bub, e.o.fl, e.o.halt, e.o.st, e.o.fc);
        end
    endtask

    // Monitor: one expected entry per instance per cycle, compared mid-cycle.
    always @(negedge clk) begin
        ent_t e;
        obs_t a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {pc_hold[0], id_hold[0], ex_bubble[0], id_flush[0], halted[0],
                 stall_cnt0, flush_cnt0};
            if (e.chk) check_obs(0, e, a);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {pc_hold[1], id_hold[1], ex_bubble[1], id_flush[1], halted[1],
                 32'(stall_cnt1), 32'(flush_cnt1)};
            if (e.chk) check_obs(1, e, a);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; id_rs1_reg = '0; id_rs2_reg = '0; ex_wb_reg = '0;
        ex_load = 1'b0; id_jump = 1'b0; id_ebreak = 1'b0;

        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        // load-use on rs1, then the same with x0 as destination
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();
        // taken jump then its flush cycle
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        idle(); idle();
        // all three hazards together
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
        idle();
        // EBREAK arriving during a flush
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        // EBREAK, drain, halt with toggling inputs, reset out of HALT
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        // reset in the middle of DRAIN
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        // drive both counters past the narrow instance's maximum
        for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        idle();
        // randomized traffic with occasional resets and EBREAKs
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 39) == 0));
        idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left q0=%0d q1=%0d required 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_hazard_ctrl.md
RV32_HAZARD_CTRL -- requirements
Module: rv32_hazard_ctrl

Interface
REQ-001 SHALL provide parameter DRAIN_CYCLES, default 3, meaning number of cycles for EX/MEM/WB to retire after EBREAK.
REQ-002 SHALL provide parameter CNT_W, default 32, meaning width of performance counters.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 id_rs1_reg  input  5  rs1 index of instruction in ID.
REQ-006 id_rs2_reg  input  5  rs2 index of instruction in ID (0 when unused).
REQ-007 id_jump  input  1  ID resolved taken branch/JAL/JALR this cycle.
REQ-008 id_ebreak  input  1  ID holds 0x00100073.
REQ-009 ex_load  input  1  EX holds a load (wb_from_mem).
REQ-010 ex_wb_reg  input  5  destination register of EX instruction.
REQ-011 pc_hold  output  1  IF keeps PC and fetched word.
REQ-012 id_hold  output  1  ID keeps its input instruction.
REQ-013 ex_bubble  output  1  ID drives NOP 0x00000013, wb_enable 0 into EX.
REQ-014 id_flush  output  1  ID discards its input (wrong-path), drives NOP.
REQ-015 halted  output  1  pipeline fully drained after EBREAK.
REQ-016 stall_cnt  output  CNT_W  cycles spent in load-use stall.
REQ-017 flush_cnt  output  CNT_W  number of taken-jump flushes.

Function
REQ-018 SHALL implement states RUN, FLUSH, DRAIN, HALT.
REQ-019 load_use SHALL be ex_load && ex_wb_reg!=0 && (ex_wb_reg==id_rs1_reg || ex_wb_reg==id_rs2_reg).
REQ-020 In RUN with load_use: pc_hold=id_hold=ex_bubble=1 same cycle (combinational); state stays RUN; stall_cnt increments; id_jump and id_ebreak ignored that cycle.
REQ-021 In RUN, no load_use, id_ebreak: pc_hold=1, ex_bubble=1; next state DRAIN, drain counter loads DRAIN_CYCLES-1.
REQ-022 In RUN, no load_use, no id_ebreak, id_jump: outputs 0 this cycle (branch passes to EX); next state FLUSH; flush_cnt increments.
REQ-023 In FLUSH: id_flush=ex_bubble=1 exactly one cycle; id_jump ignored; next state RUN; id_ebreak in FLUSH is wrong-path and SHALL be ignored.
REQ-024 In DRAIN: pc_hold=id_hold=ex_bubble=1; counter decrements each cycle; at 0 next state HALT.
REQ-025 In HALT: pc_hold=id_hold=ex_bubble=halted=1; exit only via reset.
REQ-026 Priority in RUN SHALL be load_use > id_ebreak > id_jump.
REQ-027 Counters SHALL saturate at all-ones, never wrap.
REQ-028 All outputs SHALL be 0 in RUN absent a hazard; no output X after reset.

Reset
REQ-029 Reset SHALL force state RUN, drain counter 0, stall_cnt=flush_cnt=0, halted=0, all hold/bubble/flush outputs 0 in the following cycle.
REQ-030 Reset asserted in any state (incl. DRAIN, HALT) SHALL take priority over every transition.

Structure
REQ-031 State encoding, NOP constant 0x00000013 and EBREAK constant 0x00100073 SHALL live in shared package rv32_pkg.
REQ-032 Single sub-module rv32_sat_counter (CNT_W, inc, clear) SHALL be instantiated twice for stall_cnt/flush_cnt.

Verification
REQ-033 ex_load=1, ex_wb_reg=5, id_rs1_reg=5 one cycle -> pc_hold/id_hold/ex_bubble=1 that cycle, stall_cnt=1; ex_wb_reg=0 same case -> no stall.
REQ-034 id_jump=1 one cycle -> next cycle id_flush=ex_bubble=1, following cycle all 0, flush_cnt=1.
REQ-035 id_ebreak=1 -> pc_hold=1 immediately, halted=1 after exactly 1+DRAIN_CYCLES cycles (4 at default), stays 1 with inputs toggling.
REQ-036 load_use, id_jump and id_ebreak all 1 same cycle -> stall only, state RUN, flush_cnt unchanged.
REQ-037 id_ebreak=1 while in FLUSH -> ignored, state RUN next cycle.
REQ-038 reset during DRAIN and during HALT -> next cycle halted=0, counters 0, state RUN; counters preloaded near max -> saturate at 0xFFFFFFFF.
